// File: rtl/sdram_arbiter.sv
// sdram_arbiter: slot sequencer sharing one 8-bit SDRAM controller between a video read port and a CPU port
//   i_clk, i_reset_n        : controller clock, asynchronous active-low reset
//   o_ready                 : high once the power-up refresh sequence has finished
//   i_vid_req/addr          : video read request (level, held until o_vid_ack)
//   o_vid_ack/o_vid_dout    : one-cycle ack with read data valid in the same cycle
//   i_cpu_req/we/addr/din   : CPU read/write request (level, held until o_cpu_ack)
//   o_cpu_ack/o_cpu_dout    : one-cycle ack at slot end, read data on reads only
//   o_sd_*/i_sd_dout        : controller init, address, data and ce/we/refresh strobes
module sdram_arbiter #(
    parameter int SLOT_LEN         = 8,
    parameter int DATA_SLOT        = 7,
    parameter int REFRESH_INTERVAL = 500,
    parameter int INIT_SLOTS       = 32
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    output logic        o_ready,
    input  logic        i_vid_req,
    input  logic [24:0] i_vid_addr,
    output logic        o_vid_ack,
    output logic [7:0]  o_vid_dout,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [24:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_din,
    output logic        o_cpu_ack,
    output logic [7:0]  o_cpu_dout,
    output logic        o_sd_init,
    output logic [24:0] o_sd_addr,
    output logic [7:0]  o_sd_din,
    input  logic [7:0]  i_sd_dout,
    output logic        o_sd_ce,
    output logic        o_sd_we,
    output logic        o_sd_refresh
);
    localparam int SW = $clog2(SLOT_LEN);
    localparam int RW = $clog2(REFRESH_INTERVAL);
    localparam int IW = $clog2(INIT_SLOTS + 1);
    localparam logic [SW-1:0] S_LAST = SW'(SLOT_LEN - 1);
    localparam logic [SW-1:0] S_OFF  = SW'(SLOT_LEN - 2);
    localparam logic [SW-1:0] S_DATA = SW'(DATA_SLOT);
    localparam logic [RW-1:0] R_LAST = RW'(REFRESH_INTERVAL - 1);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [1:0] OW_IDLE = 2'd0;
    localparam logic [1:0] OW_REF  = 2'd1;
    localparam logic [1:0] OW_VID  = 2'd2;
    localparam logic [1:0] OW_CPU  = 2'd3;

    logic [0:0]    r_state;
    logic [SW-1:0] r_slot;
    logic [RW-1:0] r_ref_cnt;
    logic          r_ref_pend;
    logic [IW-1:0] r_init_cnt;
    logic [1:0]    r_vid_run;
    logic [1:0]    r_owner;
    logic          r_sd_init;
    logic          r_ready;
    logic          r_sd_ce;
    logic          r_sd_we;
    logic          r_sd_refresh;
    logic [24:0]   r_sd_addr;
    logic [7:0]    r_sd_din;
    logic          r_vid_ack;
    logic          r_cpu_ack;
    logic [7:0]    r_vid_dout;
    logic [7:0]    r_cpu_dout;

    logic [SW-1:0] w_slot_nxt;
    logic          w_start;
    logic          w_run;
    logic          w_expire;
    logic          w_starve;
    logic          w_ref_take;
    logic [1:0]    w_grant;

    // Registered outputs are updated on the edge that enters slot cycle s, so
    // "at s" decisions are made from w_slot_nxt. The clock after reset release
    // holds the counter at 0 so the first init slot starts cleanly.
    always_comb begin
        w_slot_nxt = (r_sd_init || r_slot == S_LAST) ? '0 : r_slot + 1'b1;
        w_start    = w_slot_nxt == '0;
        w_run      = r_state == ST_RUN;
        w_expire   = w_run && r_ref_cnt == R_LAST;
        // Video has had two slots in a row while the CPU waited: let the CPU in.
        w_starve   = r_vid_run == 2'd2 && i_cpu_req;
        w_grant    = (!w_run || r_ref_pend) ? OW_REF :
                     (i_vid_req && !w_starve) ? OW_VID :
                     i_cpu_req ? OW_CPU : OW_IDLE;
        w_ref_take = w_start && w_run && r_ref_pend;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_INIT;
            r_slot       <= '0;
            r_ref_cnt    <= '0;
            r_ref_pend   <= 1'b0;
            r_init_cnt   <= IW'(INIT_SLOTS);
            r_vid_run    <= 2'd0;
            r_owner      <= OW_IDLE;
            r_sd_init    <= 1'b1;
            r_ready      <= 1'b0;
            r_sd_ce      <= 1'b0;
            r_sd_we      <= 1'b0;
            r_sd_refresh <= 1'b0;
            r_sd_addr    <= '0;
            r_sd_din     <= '0;
            r_vid_ack    <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_vid_dout   <= '0;
            r_cpu_dout   <= '0;
        end else begin
            r_sd_init  <= 1'b0;
            r_slot     <= w_slot_nxt;
            // A new expiry wins over a same-cycle refresh grant; a second
            // expiry while pending simply leaves the flag set.
            r_ref_pend <= w_expire | (r_ref_pend & ~w_ref_take);
            if (w_run)
                r_ref_cnt <= w_expire ? '0 : r_ref_cnt + 1'b1;
            if (!w_run && w_slot_nxt == S_LAST) begin
                r_init_cnt <= r_init_cnt - 1'b1;
                if (r_init_cnt == IW'(1)) begin
                    r_state <= ST_RUN;
                    r_ready <= 1'b1;
                end
            end
            if (w_start) begin
                r_owner      <= w_grant;
                r_sd_ce      <= w_grant == OW_VID || w_grant == OW_CPU;
                r_sd_refresh <= w_grant == OW_REF;
                r_sd_we      <= w_grant == OW_CPU && i_cpu_we;
                if (w_grant == OW_VID) begin
                    r_sd_addr <= i_vid_addr;
                    r_vid_run <= i_cpu_req ? r_vid_run + 1'b1 : 2'd0;
                end
                if (w_grant == OW_CPU) begin
                    r_sd_addr <= i_cpu_addr;
                    r_sd_din  <= i_cpu_din;
                    r_vid_run <= 2'd0;
                end
            end else if (w_slot_nxt == S_OFF) begin
                r_sd_ce      <= 1'b0;
                r_sd_refresh <= 1'b0;
            end
            if (w_slot_nxt == S_DATA && r_owner == OW_VID)
                r_vid_dout <= i_sd_dout;
            if (w_slot_nxt == S_DATA && r_owner == OW_CPU && !r_sd_we)
                r_cpu_dout <= i_sd_dout;
            r_vid_ack <= w_slot_nxt == S_LAST && r_owner == OW_VID;
            r_cpu_ack <= w_slot_nxt == S_LAST && r_owner == OW_CPU;
        end
    end

    assign o_ready      = r_ready;
    assign o_sd_init    = r_sd_init;
    assign o_sd_ce      = r_sd_ce;
    assign o_sd_we      = r_sd_we;
    assign o_sd_refresh = r_sd_refresh;
    assign o_sd_addr    = r_sd_addr;
    assign o_sd_din     = r_sd_din;
    assign o_vid_ack    = r_vid_ack;
    assign o_cpu_ack    = r_cpu_ack;
    assign o_vid_dout   = r_vid_dout;
    assign o_cpu_dout   = r_cpu_dout;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: randomized slot-level reference model check of sdram_arbiter
module tb_sdram_arbiter;
    localparam int RI        = 40;
    localparam int DATA_SLOT = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vreq = 1'b0, creq = 1'b0, cwe = 1'b0;
    logic [24:0] vaddr = '0, caddr = '0;
    logic [7:0]  cdin = '0, sdout = '0;
    logic        o_ready, o_vid_ack, o_cpu_ack, o_sd_init, o_sd_ce, o_sd_we, o_sd_refresh;
    logic [7:0]  o_vid_dout, o_cpu_dout, o_sd_din;
    logic [24:0] o_sd_addr;

    int checks = 0, errors = 0;
    int e = 0, prev_e = 257, own = 0, m_streak = 0;
    bit m_pend = 0, m_we = 0, ab = 0;
    logic [24:0] m_addr = '0;
    logic [7:0]  m_din = '0, m_vdout = '0, m_cdout = '0;

    sdram_arbiter #(.REFRESH_INTERVAL(RI)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .o_ready(o_ready),
        .i_vid_req(vreq), .i_vid_addr(vaddr), .o_vid_ack(o_vid_ack), .o_vid_dout(o_vid_dout),
        .i_cpu_req(creq), .i_cpu_we(cwe), .i_cpu_addr(caddr), .i_cpu_din(cdin),
        .o_cpu_ack(o_cpu_ack), .o_cpu_dout(o_cpu_dout),
        .o_sd_init(o_sd_init), .o_sd_addr(o_sd_addr), .o_sd_din(o_sd_din), .i_sd_dout(sdout),
        .o_sd_ce(o_sd_ce), .o_sd_we(o_sd_we), .o_sd_refresh(o_sd_refresh)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    // Refresh timer expiries land on edges 256+RI*m (m>=1); count those at or before edge x.
    function automatic int n_exp(input int x);
        return (x < 256 + RI) ? 0 : (x - 256) / RI;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, 32'(o_ready), 0);
        chk({tag, "_sd_init"}, 32'(o_sd_init), 1);
        chk({tag, "_strobes"}, 32'({o_sd_ce, o_sd_we, o_sd_refresh}), 0);
        chk({tag, "_acks"}, 32'({o_vid_ack, o_cpu_ack}), 0);
        chk({tag, "_sd_addr"}, 32'(o_sd_addr), 0);
        chk({tag, "_sd_din"}, 32'(o_sd_din), 0);
        chk({tag, "_vid_dout"}, 32'(o_vid_dout), 0);
        chk({tag, "_cpu_dout"}, 32'(o_cpu_dout), 0);
    endtask

    task automatic init_seq();
        int nref;
        logic prv;
        e = 0;
        nref = 0;
        prv = 1'b0;
        chk("init_pulse", 32'(o_sd_init), 1);
        for (int i = 1; i <= 256; i++) begin
            tick();
            chk("init_sd_init", 32'(o_sd_init), 0);
            chk("init_refresh", 32'(o_sd_refresh), 32'(((e - 1) % 8) <= 5));
            chk("init_ce", 32'(o_sd_ce), 0);
            chk("init_ready", 32'(o_ready), 32'(e >= 256));
            chk("init_acks", 32'({o_vid_ack, o_cpu_ack}), 0);
            if (o_sd_refresh && !prv) nref++;
            prv = o_sd_refresh;
        end
        chk("init_ref_edges", nref, 32);
        prev_e = 257; m_pend = 0; m_streak = 0; m_we = 0;
        m_addr = '0; m_din = '0; m_vdout = '0; m_cdout = '0;
    endtask

    // One 8-clock slot: predict the owner from the rules, then check every cycle.
    task automatic run_slot(input logic [7:0] dout, input bit abort, output bit aborted);
        int E;
        E = e + 1;
        if (n_exp(E - 1) > n_exp(prev_e - 1)) m_pend = 1;
        prev_e = E;
        if (m_pend) begin
            own = 1; m_pend = 0;
        end else if (vreq && !(creq && m_streak >= 2)) begin
            own = 2; m_streak = creq ? m_streak + 1 : 0;
        end else if (creq) begin
            own = 3; m_streak = 0;
        end else own = 0;
        if (own == 2) begin m_addr = vaddr; m_we = 0; end
        else if (own == 3) begin m_addr = caddr; m_din = cdin; m_we = cwe; end
        else m_we = 0;
        sdout = dout;
        aborted = 0;
        for (int s = 0; s < 8; s++) begin
            tick();
            if (s == DATA_SLOT && own == 2) m_vdout = dout;
            if (s == DATA_SLOT && own == 3 && !m_we) m_cdout = dout;
            chk("sd_ce", 32'(o_sd_ce), 32'(own >= 2 && s <= 5));
            chk("sd_refresh", 32'(o_sd_refresh), 32'(own == 1 && s <= 5));
            chk("sd_we", 32'(o_sd_we), 32'(m_we));
            chk("sd_addr", 32'(o_sd_addr), 32'(m_addr));
            chk("sd_din", 32'(o_sd_din), 32'(m_din));
            chk("vid_ack", 32'(o_vid_ack), 32'(own == 2 && s == 7));
            chk("cpu_ack", 32'(o_cpu_ack), 32'(own == 3 && s == 7));
            chk("vid_dout", 32'(o_vid_dout), 32'(m_vdout));
            chk("cpu_dout", 32'(o_cpu_dout), 32'(m_cdout));
            chk("ready", 32'(o_ready), 1);
            if (abort && own == 3 && s == 4) begin
                aborted = 1;
                return;
            end
        end
    endtask

    task automatic next_reqs();
        if (own == 2) begin vreq = 1'($urandom_range(0, 1)); vaddr = 25'($urandom); end
        else if (!vreq) begin
            if ($urandom_range(0, 2) == 0) begin vreq = 1; vaddr = 25'($urandom); end
        end else if ($urandom_range(0, 9) == 0) vreq = 0;
        if (own == 3 || !creq) begin
            creq = (own == 3) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 2) == 0);
            cwe = 1'($urandom_range(0, 1)); caddr = 25'($urandom); cdin = 8'($urandom);
        end else if ($urandom_range(0, 9) == 0) creq = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        #4 rst_n = 1'b1;
        init_seq();

        vreq = 1; vaddr = 25'h0001234;
        run_slot(8'hA5, 0, ab);
        chk("vid_read_owner", own, 2);
        chk("vid_read_dout", 32'(o_vid_dout), 32'hA5);
        vreq = 0;

        creq = 1; cwe = 1; caddr = 25'h1FFFFFF; cdin = 8'h3C;
        run_slot(8'h77, 0, ab);
        chk("cpu_wr_owner", own, 3);
        chk("cpu_wr_dout_hold", 32'(o_cpu_dout), 0);

        vreq = 1; vaddr = 25'h0ABCDE; creq = 1; cwe = 0; caddr = 25'h0001000;
        for (int i = 0; i < 52; i++) run_slot(8'($urandom), 0, ab);

        for (int i = 0; i < 120; i++) begin
            next_reqs();
            run_slot(8'($urandom), 0, ab);
        end

        vreq = 0; creq = 1; cwe = 0; caddr = 25'($urandom);
        for (int i = 0; i < 6 && !ab; i++) run_slot(8'h5A, 1, ab);
        chk("abort_reached", 32'(ab), 1);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("rst_no_cpu_ack", 32'(o_cpu_ack), 0);
        end
        check_reset("rst_hold");
        vreq = 1; creq = 1;
        #4 rst_n = 1'b1;
        init_seq();
        for (int i = 0; i < 6; i++) run_slot(8'($urandom), 0, ab);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
